vga_timing_gen: RTL

- Parametrised successor to the fixed 640x480 VGA controller.
- Generates pixel-enable, hsync/vsync/data-enable, active-area pixel coordinates, line/frame strobes and a divided frame tick (replaces ad-hoc cursor-rate counters), all from one system clock.
- Sync/DE are delayed by a configurable pipeline so they align with downstream RAM-fetch/colour logic.
- Sits between the clock source and the pixel compositor/sprite logic.

---
 rtl/vga_pkg.sv | 40 ++++
 rtl/vga_sync_pipe.sv | 35 +++
 rtl/vga_timing_gen.sv | 122 ++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared timing defaults, region-boundary helpers and the sync bundle type
// used by the VGA timing generator and its output delay line.
package vga_pkg;

  localparam int H_ACTIVE_DEF  = 640;
  localparam int H_FP_DEF      = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BP_DEF      = 48;
  localparam int V_ACTIVE_DEF  = 480;
  localparam int V_FP_DEF      = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BP_DEF      = 29;
  localparam int CLK_DIV_DEF   = 4;
  localparam int PIPE_DEF      = 2;
  localparam int FRAME_DIV_DEF = 2;
  localparam int CW_DEF        = 10;

  localparam bit HS_POL_DEF = 1'b0;
  localparam bit VS_POL_DEF = 1'b0;

  // Active-high sync bundle; polarity is applied only at the outputs.
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } sync_t;

  function automatic int span_total(input int sync, input int bp, input int active, input int fp);
    return sync + bp + active + fp;
  endfunction

  function automatic int act_first(input int sync, input int bp);
    return sync + bp;
  endfunction

  function automatic int act_last_excl(input int sync, input int bp, input int active);
    return sync + bp + active;
  endfunction

endpackage

// File: rtl/vga_sync_pipe.sv
// Enable-gated delay line for the {hs,vs,de} bundle; clr flushes every stage
// to the inactive (all-zero) bundle.
module vga_sync_pipe
  import vga_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic  clk,
  input  logic  clr,
  input  logic  i_en,
  input  sync_t i_d,
  output sync_t o_q
);

  if (DEPTH == 0) begin : g_bypass
    logic w_unused;
    assign w_unused = &{1'b0, clk, i_en};
    // Without registers the reset must still force the inactive bundle.
    assign o_q = clr ? sync_t'('0) : i_d;
  end else begin : g_pipe
    sync_t r_stage [DEPTH];

    always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
        for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
      end else if (i_en) begin
        r_stage[0] <= i_d;
        for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
      end
    end

    assign o_q = r_stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel enable, counters, stage-0 decode,
// delayed sync/DE, line/frame strobes and divided frame tick.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = H_ACTIVE_DEF,
  parameter int H_FP      = H_FP_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BP      = H_BP_DEF,
  parameter int V_ACTIVE  = V_ACTIVE_DEF,
  parameter int V_FP      = V_FP_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BP      = V_BP_DEF,
  parameter bit HS_POL    = HS_POL_DEF,
  parameter bit VS_POL    = VS_POL_DEF,
  parameter int CLK_DIV   = CLK_DIV_DEF,
  parameter int PIPE      = PIPE_DEF,
  parameter int FRAME_DIV = FRAME_DIV_DEF,
  parameter int CW        = CW_DEF
) (
  input  logic          clk,
  input  logic          clr,
  output logic          pix_en,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic          de_early,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  output logic          frame_tick,
  output logic [15:0]   frame_cnt
);

  localparam int H_TOTAL = span_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
  localparam int V_TOTAL = span_total(V_SYNC, V_BP, V_ACTIVE, V_FP);
  localparam int HA0 = act_first(H_SYNC, H_BP);
  localparam int HA1 = act_last_excl(H_SYNC, H_BP, H_ACTIVE);
  localparam int VA0 = act_first(V_SYNC, V_BP);
  localparam int VA1 = act_last_excl(V_SYNC, V_BP, V_ACTIVE);
  localparam int DW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int FW  = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  if (H_TOTAL >= (1 << CW) || V_TOTAL >= (1 << CW) || CLK_DIV < 1 || FRAME_DIV < 1 || PIPE < 0)
  begin : g_param_err
    $error("vga_timing_gen: illegal parameter set (totals must fit in CW bits)");
  end

  logic [DW-1:0] r_div;
  logic          r_pix_en;
  logic [CW-1:0] r_hc;
  logic [CW-1:0] r_vc;
  logic [15:0]   r_frame_cnt;
  logic [FW-1:0] r_frame_div_cnt;
  logic          w_hc_wrap;
  logic          w_vc_wrap;

  assign w_hc_wrap = (r_hc == CW'(H_TOTAL - 1));
  assign w_vc_wrap = (r_vc == CW'(V_TOTAL - 1));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_div           <= '0;
      r_pix_en        <= 1'b0;
      r_hc            <= '0;
      r_vc            <= '0;
      r_frame_cnt     <= '0;
      r_frame_div_cnt <= '0;
    end else begin
      r_div    <= (r_div == DW'(CLK_DIV - 1)) ? '0 : r_div + DW'(1);
      r_pix_en <= (r_div == DW'(CLK_DIV - 1));
      if (r_pix_en) begin
        r_hc <= w_hc_wrap ? '0 : r_hc + CW'(1);
        if (w_hc_wrap) r_vc <= w_vc_wrap ? '0 : r_vc + CW'(1);
      end
      if (frame_start) begin
        r_frame_cnt     <= r_frame_cnt + 16'd1;
        r_frame_div_cnt <= frame_tick ? '0 : r_frame_div_cnt + FW'(1);
      end
    end
  end

  // Stage 0: combinational decode of the registered counters
  logic  w_hs0;
  logic  w_vs0;
  logic  w_h_act;
  logic  w_v_act;
  sync_t w_stage0;
  sync_t w_piped;

  assign w_hs0    = (r_hc < CW'(H_SYNC));
  assign w_vs0    = (r_vc < CW'(V_SYNC));
  assign w_h_act  = (r_hc >= CW'(HA0)) && (r_hc < CW'(HA1));
  assign w_v_act  = (r_vc >= CW'(VA0)) && (r_vc < CW'(VA1));
  assign de_early = w_h_act && w_v_act;
  assign x        = de_early ? r_hc - CW'(HA0) : '0;
  assign y        = de_early ? r_vc - CW'(VA0) : '0;
  assign w_stage0 = {w_hs0, w_vs0, de_early};

  // Stages 1..PIPE: delay line advancing once per pixel
  vga_sync_pipe #(
    .DEPTH (PIPE)
  ) u_sync_pipe (
    .clk  (clk),
    .clr  (clr),
    .i_en (r_pix_en),
    .i_d  (w_stage0),
    .o_q  (w_piped)
  );

  assign hsync = w_piped.hs ^ ~HS_POL;
  assign vsync = w_piped.vs ^ ~VS_POL;
  assign de    = w_piped.de;

  assign pix_en      = r_pix_en;
  assign line_start  = r_pix_en && (r_hc == '0);
  assign frame_start = line_start && (r_vc == '0);
  assign frame_tick  = frame_start && (r_frame_div_cnt == FW'(FRAME_DIV - 1));
  assign frame_cnt   = r_frame_cnt;

endmodule
